// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA raster: 640x480@60 default geometry, the
//   derived line/frame totals, sync window bounds and the counter width.
//   Also provides a small inclusive range test used by the sync decode.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  // Inclusive window test on a raster count.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick
//   Divides clk into a one-cycle pixel-enable strobe every CLK_DIV clocks.
//   Ports:
//     clk        system clock
//     rst_n      async active-low reset
//     en         run enable; low clears the divider on the next edge
//     pix_tick   registered strobe, high the cycle after div count hits CLK_DIV-1
//     pix_tick_d next-state of pix_tick; lets the raster counters load on
//                the same edge the strobe rises, so pix_x/pix_y and the
//                strobe always describe the same pixel
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick,
  output logic pix_tick_d
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          pix_tick_q;

  assign pix_tick_d = en && (div_q == DW'(CLK_DIV - 1));
  assign pix_tick   = pix_tick_q;

  always_comb begin
    div_d = div_q + DW'(1);
    if (!en || pix_tick_d) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   VGA raster sequencer. Everything runs on clk; pix_tick qualifies pixels.
//   Ports:
//     clk, rst_n       system clock, async active-low reset
//     en               run enable; low returns the raster to its idle state
//     pix_tick         one-clk pixel strobe every CLK_DIV clks
//     hsync, vsync     sync outputs, active level SYNC_POL
//     video_on         current position is in the visible area
//     pix_x, pix_y     current raster position
//     line_start       pulse with the tick where pix_x becomes 0
//     frame_start      pulse with the tick where (pix_x,pix_y) becomes (0,0)
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_ctrl: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << CNT_W)) begin : g_chk_h
    $error("vga_timing_ctrl: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_chk_v
    $error("vga_timing_ctrl: V_TOTAL exceeds counter range");
  end

  logic pix_tick_d;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pix_tick   (pix_tick),
    .pix_tick_d (pix_tick_d)
  );

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [CNT_W-1:0] h_nxt, v_nxt;

  // Next raster position, used only when a tick is about to rise.
  always_comb begin
    h_nxt = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
    v_nxt = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
  end

  // Decode is computed from the next position so the registered outputs
  // line up with pix_x/pix_y with no relative latency.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    von_d = von_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (!en) begin
      h_d   = H_LAST;
      v_d   = V_LAST;
      hs_d  = ~SYNC_POL;
      vs_d  = ~SYNC_POL;
      von_d = 1'b0;
    end else if (pix_tick_d) begin
      h_d   = h_nxt;
      v_d   = v_nxt;
      hs_d  = in_range(h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_d  = in_range(v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      von_d = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
      ls_d  = (h_nxt == '0);
      fs_d  = (h_nxt == '0) && (v_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      von_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       tick, hs, vs, von, ls, fs;
    logic [9:0] x, y;
  } obs_t;

  bit clk;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Instance A: default 640x480, CLK_DIV=4, active-low syncs.
  logic       rst_a_n, en_a;
  logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;

  vga_timing_ctrl u_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .pix_tick(a_tick),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .pix_x(a_x), .pix_y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  // Instance B: CLK_DIV=1, active-high syncs, short frame (15 lines).
  logic       rst_b_n, en_b;
  logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;

  vga_timing_ctrl #(
    .CLK_DIV(1), .SYNC_POL(1'b1),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .pix_tick(b_tick),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .pix_x(b_x), .pix_y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  function automatic obs_t obs_a();
    return {a_tick, a_hs, a_vs, a_von, a_ls, a_fs, a_x, a_y};
  endfunction

  function automatic obs_t obs_b();
    return {b_tick, b_hs, b_vs, b_von, b_ls, b_fs, b_x, b_y};
  endfunction

  // Closed-form reference: cnt = clocks seen with en=1 since the raster
  // last went idle. Tick n (1-based) lands on raster index n-1.
  function automatic obs_t model(int cnt, int d, int ht, int vt, int ha, int va,
                                 int hs0, int hs1, int vs0, int vs1, bit pol);
    obs_t e;
    int n, t, x, y;
    n = cnt / d;
    if (n == 0) begin
      x = ht - 1; y = vt - 1;
    end else begin
      t = n - 1; x = t % ht; y = (t / ht) % vt;
    end
    e.tick = (cnt > 0) && (cnt % d == 0);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.von  = (x < ha) && (y < va);
    e.hs   = (x >= hs0 && x <= hs1) ? pol : !pol;
    e.vs   = (y >= vs0 && y <= vs1) ? pol : !pol;
    e.ls   = e.tick && (x == 0);
    e.fs   = e.ls && (y == 0);
    return e;
  endfunction

  // Scoreboard: each clock edge pushes the expected post-edge outputs.
  int   ca = 0, cb = 0;
  obs_t qa[$], qb[$];

  always @(posedge clk) begin
    if (!rst_a_n || !en_a) ca = 0; else ca++;
    if (!rst_b_n || !en_b) cb = 0; else cb++;
    qa.push_back(model(ca, 4, 800, 525, 640, 480, 656, 751, 490, 491, 1'b0));
    qb.push_back(model(cb, 1, 800, 15, 640, 8, 656, 751, 10, 11, 1'b1));
  end

  // Advance to the next falling edge and pop the expectations for the
  // preceding rising edge.
  task automatic nxt(output obs_t ea, output obs_t eb);
    @(negedge clk);
    if (qa.size() == 0 || qb.size() == 0) begin
      ncmp++; nfail++;
      $display("FAIL scoreboard_empty: got %0d/%0d entries, want >=1", qa.size(), qb.size());
      ea = '0; eb = '0;
    end else begin
      ea = qa[$]; qa.delete();
      eb = qb[$]; qb.delete();
    end
  endtask

  task automatic test_reset();
    obs_t ea, eb, oa, ob;
    rst_a_n = 0; rst_b_n = 0; en_a = 0; en_b = 0;
    nxt(ea, eb); nxt(ea, eb);
    oa = obs_a(); ob = obs_b();
    ncmp++; if (oa !== {6'b011000, 10'd799, 10'd524}) begin nfail++;
      $display("FAIL reset_a: got %h want %h", oa, {6'b011000, 10'd799, 10'd524}); end
    ncmp++; if (ob !== {6'b000000, 10'd799, 10'd14}) begin nfail++;
      $display("FAIL reset_b: got %h want %h", ob, {6'b000000, 10'd799, 10'd14}); end
    rst_a_n = 1; rst_b_n = 1;
    for (int c = 0; c < 3; c++) begin
      nxt(ea, eb);
      oa = obs_a(); ob = obs_b();
      ncmp++; if (oa !== ea) begin nfail++;
        $display("FAIL idle_a: got %h want %h", oa, ea); end
      ncmp++; if (ob !== eb) begin nfail++;
        $display("FAIL idle_b: got %h want %h", ob, eb); end
    end
  endtask

  task automatic test_first_tick();
    obs_t ea, eb, oa;
    int first = -1;
    en_a = 1;
    for (int c = 1; c <= 12; c++) begin
      nxt(ea, eb);
      oa = obs_a();
      ncmp++; if (oa !== ea) begin nfail++;
        $display("FAIL first_tick_seq c=%0d: got %h want %h", c, oa, ea); end
      if (oa.tick && first < 0) first = c;
      if (c == 4) begin
        ncmp++; if ({oa.tick, oa.ls, oa.fs, oa.x, oa.y} !== {3'b111, 20'd0}) begin nfail++;
          $display("FAIL first_tick_origin: got %h want %h", {oa.tick, oa.ls, oa.fs, oa.x, oa.y}, {3'b111, 20'd0}); end
      end
    end
    ncmp++; if (first !== 4) begin nfail++;
      $display("FAIL first_tick_latency: got %0d want 4", first); end
  endtask

  task automatic test_line();
    obs_t ea, eb, oa;
    int ls_seen = 0, ticks = 0, hs_cnt = 0, vid_cnt = 0, hs_lo = 9999, hs_hi = -1;
    for (int c = 0; c < 8000 && ls_seen < 2; c++) begin
      nxt(ea, eb);
      oa = obs_a();
      ncmp++; if (oa !== ea) begin nfail++;
        $display("FAIL line_seq: got %h want %h", oa, ea); end
      if (oa.tick && oa.ls) ls_seen++;
      if (oa.tick && ls_seen == 1) begin
        ticks++;
        if (oa.von) vid_cnt++;
        if (oa.hs == 1'b0) begin
          hs_cnt++;
          if (int'(oa.x) < hs_lo) hs_lo = int'(oa.x);
          if (int'(oa.x) > hs_hi) hs_hi = int'(oa.x);
        end
      end
    end
    ncmp++; if (ls_seen != 2) begin nfail++;
      $display("FAIL line_start_timeout: got %0d want 2", ls_seen); end
    ncmp++; if (ticks != 800) begin nfail++;
      $display("FAIL line_period: got %0d want 800", ticks); end
    ncmp++; if (hs_cnt != 96) begin nfail++;
      $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
    ncmp++; if (hs_lo != 656 || hs_hi != 751) begin nfail++;
      $display("FAIL hsync_window: got %0d..%0d want 656..751", hs_lo, hs_hi); end
    ncmp++; if (vid_cnt != 640) begin nfail++;
      $display("FAIL video_width: got %0d want 640", vid_cnt); end
  endtask

  task automatic test_en_drop();
    obs_t ea, eb, oa;
    bit hit = 0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      nxt(ea, eb);
      oa = obs_a();
      ncmp++; if (oa !== ea) begin nfail++;
        $display("FAIL pre_drop_seq: got %h want %h", oa, ea); end
      hit = oa.tick && oa.x == 10'd300 && oa.y == 10'd3;
    end
    ncmp++; if (!hit) begin nfail++;
      $display("FAIL drop_point_timeout: got %0d want 1", hit); end
    en_a = 0;
    nxt(ea, eb);
    oa = obs_a();
    ncmp++; if (oa !== {6'b011000, 10'd799, 10'd524}) begin nfail++;
      $display("FAIL en_drop_state: got %h want %h", oa, {6'b011000, 10'd799, 10'd524}); end
    nxt(ea, eb); nxt(ea, eb);
    en_a = 1;
    for (int c = 1; c <= 8; c++) begin
      nxt(ea, eb);
      oa = obs_a();
      ncmp++; if (oa !== ea) begin nfail++;
        $display("FAIL restart_seq c=%0d: got %h want %h", c, oa, ea); end
      if (c == 4) begin
        ncmp++; if ({oa.tick, oa.fs, oa.x, oa.y} !== {2'b11, 20'd0}) begin nfail++;
          $display("FAIL restart_origin: got %h want %h", {oa.tick, oa.fs, oa.x, oa.y}, {2'b11, 20'd0}); end
      end
    end
  endtask

  task automatic test_frame();
    obs_t ea, eb, ob;
    int fs_n = 0, fs1 = -1, fs2 = -1, last_ls = -1, ls_bad = 0, ls_n = 0, tick_low = 0;
    int vs_lo = 9999, vs_hi = -1, hs_lo = 9999, hs_hi = -1;
    bit wrap = 0;
    logic [9:0] prev_y = 10'd14;
    en_b = 1;
    for (int c = 1; c <= 13000 && fs_n < 2; c++) begin
      nxt(ea, eb);
      ob = obs_b();
      ncmp++; if (ob !== eb) begin nfail++;
        $display("FAIL frame_seq c=%0d: got %h want %h", c, ob, eb); end
      if (!ob.tick) tick_low++;
      if (ob.fs) begin fs_n++; if (fs_n == 1) fs1 = c; else fs2 = c; end
      if (ob.ls) begin
        ls_n++;
        if (last_ls >= 0 && c - last_ls != 800) ls_bad++;
        last_ls = c;
        if (ob.vs) begin
          if (int'(ob.y) < vs_lo) vs_lo = int'(ob.y);
          if (int'(ob.y) > vs_hi) vs_hi = int'(ob.y);
        end
      end
      if (ob.hs && ob.y == 10'd0) begin
        if (int'(ob.x) < hs_lo) hs_lo = int'(ob.x);
        if (int'(ob.x) > hs_hi) hs_hi = int'(ob.x);
      end
      if (prev_y == 10'd14 && ob.y == 10'd0 && c > 1) wrap = 1;
      prev_y = ob.y;
    end
    ncmp++; if (fs1 != 1) begin nfail++;
      $display("FAIL b_first_frame: got %0d want 1", fs1); end
    ncmp++; if (fs2 - fs1 != 12000) begin nfail++;
      $display("FAIL frame_period: got %0d want 12000", fs2 - fs1); end
    ncmp++; if (ls_bad != 0 || ls_n != 16) begin nfail++;
      $display("FAIL b_line_period: got %0d bad of %0d want 0 of 16", ls_bad, ls_n); end
    ncmp++; if (tick_low != 0) begin nfail++;
      $display("FAIL tick_constant: got %0d low cycles want 0", tick_low); end
    ncmp++; if (vs_lo != 10 || vs_hi != 11) begin nfail++;
      $display("FAIL vsync_window: got %0d..%0d want 10..11", vs_lo, vs_hi); end
    ncmp++; if (hs_lo != 656 || hs_hi != 751) begin nfail++;
      $display("FAIL hsync_pos_window: got %0d..%0d want 656..751", hs_lo, hs_hi); end
    ncmp++; if (!wrap) begin nfail++;
      $display("FAIL y_wrap: got %0d want 1", wrap); end
  endtask

  task automatic test_async_reset();
    obs_t ea, eb, ob;
    bit hit = 0;
    for (int c = 0; c < 13000 && !hit; c++) begin
      nxt(ea, eb);
      ob = obs_b();
      ncmp++; if (ob !== eb) begin nfail++;
        $display("FAIL pre_reset_seq: got %h want %h", ob, eb); end
      hit = ob.y == 10'd10 && ob.x == 10'd100;
    end
    ncmp++; if (!(hit && ob.vs)) begin nfail++;
      $display("FAIL reset_point: got hit=%0d vs=%0d want 1 1", hit, ob.vs); end
    #2 rst_b_n = 0;
    #1 ob = obs_b();
    ncmp++; if (ob !== {6'b000000, 10'd799, 10'd14}) begin nfail++;
      $display("FAIL async_reset: got %h want %h", ob, {6'b000000, 10'd799, 10'd14}); end
    nxt(ea, eb);
    ob = obs_b();
    ncmp++; if (ob !== eb) begin nfail++;
      $display("FAIL reset_hold: got %h want %h", ob, eb); end
    #2 rst_b_n = 1;
    for (int c = 1; c <= 4; c++) begin
      nxt(ea, eb);
      ob = obs_b();
      ncmp++; if (ob !== eb) begin nfail++;
        $display("FAIL recover_seq c=%0d: got %h want %h", c, ob, eb); end
      if (c == 1) begin
        ncmp++; if ({ob.tick, ob.fs, ob.x, ob.y} !== {2'b11, 20'd0}) begin nfail++;
          $display("FAIL recover_origin: got %h want %h", {ob.tick, ob.fs, ob.x, ob.y}, {2'b11, 20'd0}); end
      end
    end
  endtask

  initial begin
    rst_a_n = 0; rst_b_n = 0; en_a = 0; en_b = 0;
    test_reset();
    test_first_tick();
    test_line();
    test_en_drop();
    test_frame();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
